fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch front end that produces the per-cycle fetch bundle consumed by the IF/ID pipeline register. Holds the PC, issues one instruction-bus request at a time, buffers the returned instruction until the decode side accepts it, and applies redirects (branch/jump/exception) from later stages. Data returned for a request that a redirect has superseded is discarded.

## Interface
- RESET_PC, 64'h8000_0000, PC loaded on reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low (asserted at 0); clears all state immediately
- ireq_valid  out  1  instruction-bus request valid
- ireq_addr  out  64  request address, stable while ireq_valid=1 until the data_ok cycle
- iresp_data_ok  in  1  one-cycle pulse: response for the outstanding request
- iresp_data  in  32  instruction word, valid with iresp_data_ok
- id_ready  in  1  IF/ID register will capture this cycle (its if_id_write)
- stallpc  in  1  hazard stall: hold PC and buffered instruction
- redirect_valid  in  1  next PC must become redirect_pc
- redirect_pc  in  64  redirect target, used unchanged
- out_valid  out  1  bundle valid (fetch_data_t valid bit)
- out_pc  out  64  PC of bundled instruction
- out_instr  out  32  raw instruction word

## Operation
- Registers: pc, req_addr, instr_buf, state ∈ {FETCH, DROP, HOLD}.
- FETCH: ireq_valid=1, ireq_addr=req_addr.
  - redirect_valid: pc<=redirect_pc. If data_ok this cycle: discard data, req_addr<=redirect_pc, stay FETCH. Otherwise go DROP, leaving req_addr unchanged.
  - No redirect, data_ok: instr_buf<=iresp_data, go HOLD.
  - Neither: stay FETCH.
- DROP: an outstanding request is completing, and its data is discarded.
  - ireq_valid=1, ireq_addr=req_addr (old address).
  - redirect_valid: pc<=redirect_pc, stay DROP. A later redirect overrides an earlier one.
  - data_ok: discard, req_addr<=pc (or redirect_pc if redirect_valid this cycle), go FETCH.
- HOLD: ireq_valid=0, out_valid=1, out_pc=pc, out_instr=instr_buf.
  - redirect_valid: highest priority. Buffered instruction dropped, pc<=redirect_pc, req_addr<=redirect_pc, go FETCH.
  - Else id_ready && !stallpc: consumed. pc<=pc+4, req_addr<=pc+4, go FETCH.
  - Else: hold all state.
- out_valid=0 in FETCH/DROP. out_pc=pc and out_instr=instr_buf are driven in all states.
- PC arithmetic is 64-bit modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- At most one request outstanding. A request is never withdrawn before data_ok.
- stallpc is ignored in FETCH/DROP. It affects only consumption in HOLD.

## Timing
- Reset values: state=FETCH, pc=req_addr=RESET_PC, instr_buf=0, out_valid=0, ireq_valid=1 from the first cycle after release, ireq_addr=RESET_PC.
- Reset asserted mid-transaction: state clears immediately. The outstanding request is abandoned (the bus is reset by the same signal).
- Fetch latency: with data_ok in the first FETCH cycle, out_valid rises the next cycle.
- Throughput: one instruction per 2 cycles with a zero-wait bus.
- Redirect to new request:
  - In HOLD, or in FETCH with a coincident data_ok: ireq_addr=target the next cycle.
  - Otherwise: ireq_addr=target in the cycle after the pending data_ok.
- All outputs are functions of registers only; there is no combinational path from inputs to outputs.

## Test plan
- Reset release, bus answers in 1 cycle with 32'h0000_0013 → ireq_addr=8000_0000. Next cycle out_valid=1, out_pc=8000_0000, out_instr=0000_0013. After id_ready, ireq_addr=8000_0004.
- HOLD with stallpc=1 and id_ready=1 for 3 cycles → out_* unchanged, ireq_valid=0. Drop stallpc → pc advances by 4 the next cycle.
- Redirect to 8000_1000 while waiting (data_ok 2 cycles later with 32'hDEAD_BEEF) → DEADBEEF never appears with out_valid=1. ireq_addr stays 8000_0000 until data_ok, then 8000_1000.
- Redirect in HOLD coincident with id_ready → buffer dropped, next ireq_addr = redirect target, not pc+4.
- Two redirects during DROP (8000_2000, then 8000_3000) → first new request uses 8000_3000.
- pc=FFFF_FFFF_FFFF_FFFC consumed → next ireq_addr=0.
- Reset asserted in DROP → immediate FETCH at RESET_PC, out_valid=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit boundary bundle: instruction-bus handshake, redirect/hazard inputs
// from later stages, and the fetch bundle presented to the IF/ID register.
interface fetch_unit_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        id_ready;
    logic        stallpc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    // master = the fetch unit itself
    modport master (
        output ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        input  iresp_data_ok, iresp_data, id_ready, stallpc, redirect_valid, redirect_pc
    );

    // slave = bus, decode and redirect sources surrounding the fetch unit
    modport slave (
        input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        output iresp_data_ok, iresp_data, id_ready, stallpc, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding bus request, a single-entry
// instruction buffer, and redirect handling that discards superseded responses.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {FETCH, DROP, HOLD} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [31:0] instr_buf_q, instr_buf_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            instr_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            instr_buf_q <= instr_buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        instr_buf_d = instr_buf_q;
        unique case (state_q)
            FETCH: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                    // The in-flight request cannot be withdrawn; if it is not
                    // finishing now, wait in DROP for its response to discard.
                    if (bus.iresp_data_ok) req_addr_d = bus.redirect_pc;
                    else                   state_d    = DROP;
                end else if (bus.iresp_data_ok) begin
                    instr_buf_d = bus.iresp_data;
                    state_d     = HOLD;
                end
            end
            DROP: begin
                if (bus.redirect_valid) pc_d = bus.redirect_pc;
                if (bus.iresp_data_ok) begin
                    req_addr_d = bus.redirect_valid ? bus.redirect_pc : pc_q;
                    state_d    = FETCH;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d       = bus.redirect_pc;
                    req_addr_d = bus.redirect_pc;
                    state_d    = FETCH;
                end else if (bus.id_ready && !bus.stallpc) begin
                    pc_d       = pc_q + 64'd4;
                    req_addr_d = pc_q + 64'd4;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Outputs depend on registers only.
    assign bus.ireq_valid = (state_q != HOLD);
    assign bus.ireq_addr  = req_addr_q;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_pc     = pc_q;
    assign bus.out_instr  = instr_buf_q;

    a_req_stable: assert property (@(posedge clk) disable iff (!reset)
        (bus.ireq_valid && !bus.iresp_data_ok) |=> (bus.ireq_valid && $stable(bus.ireq_addr)));

endmodule
